// File: rtl/queue_reader_pkg.sv
// Shared constants for the byte-queue read side: pointer/address width helpers,
// output FIFO geometry and FSM state encoding.
package queue_reader_pkg;

   // Output FIFO geometry; the credit counter spans 0..FIFO_DEPTH inclusive
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_AW    = 2;
   localparam int unsigned FIFO_CW    = 3;
   localparam int unsigned CREDIT_W   = 3;
   localparam int unsigned BYTE_W     = 8;

   // FSM state encoding
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   // Byte address width for a queue of size_kb KiB
   function automatic int unsigned addr_width(input int unsigned size_kb);
      return $clog2(size_kb * 1024);
   endfunction

   // Pointer width: address plus one wrap bit
   function automatic int unsigned ptr_width(input int unsigned size_kb);
      return addr_width(size_kb) + 1;
   endfunction

endpackage

// File: rtl/queue_reader_fifo.sv
// 4-entry byte FIFO with push/pop/clear and a registered head byte/valid.
// Push and pop in the same cycle both apply; the caller never pops when empty
// and never pushes when full.
module queue_reader_fifo
   import queue_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [BYTE_W-1:0] o_head,
   output logic              o_head_valid
);

   logic [BYTE_W-1:0]  mem_q [FIFO_DEPTH];
   logic [BYTE_W-1:0]  mem_d [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_q, wr_d;
   logic [FIFO_AW-1:0] rd_q, rd_d;
   logic [FIFO_CW-1:0] cnt_q, cnt_d;
   logic [BYTE_W-1:0]  head_q, head_d;
   logic               valid_q, valid_d;

   // Next storage/pointer state; head is looked up from the next state so it is registered
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (i_clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (i_push) begin
            mem_d[wr_q] = i_push_data;
            wr_d        = wr_q + FIFO_AW'(1);
         end
         if (i_pop) begin
            rd_d = rd_q + FIFO_AW'(1);
         end
         cnt_d = cnt_q + FIFO_CW'(i_push) - FIFO_CW'(i_pop);
      end
      head_d  = mem_d[rd_d];
      valid_d = (cnt_d != '0);
   end

   // FIFO state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         valid_q <= valid_d;
      end
   end

   assign o_head       = head_q;
   assign o_head_valid = valid_q;

endmodule

// File: rtl/queue_reader.sv
// Read-side initiator for the byte queue memory. Follows the producer write pointer,
// issues one-byte reads (1-cycle memory latency), buffers returned bytes in a 4-entry
// FIFO and streams them out with valid/ready; returns the consumed pointer.
// Optional build macro QUEUE_READER_LEVEL_EN adds o_level (registered unread-byte count).
module queue_reader
   import queue_reader_pkg::*;
#(
   parameter  int unsigned SIZE_KB = 1,
   localparam int unsigned AW      = addr_width(SIZE_KB),
   localparam int unsigned PW      = ptr_width(SIZE_KB)
) (
   input  logic              i_master_clk,
   input  logic              i_reset_n,
   input  logic [PW-1:0]     i_write_ptr,
   output logic [PW-1:0]     o_read_ptr,
   output logic [AW-1:0]     o_mem_read_address,
   output logic              o_mem_read_request,
   input  logic [BYTE_W-1:0] i_mem_read_data,
   input  logic              i_mem_read_data_valid,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_data_valid,
   input  logic              i_data_ready,
   input  logic              i_flush,
   output logic              o_empty
`ifdef QUEUE_READER_LEVEL_EN
   ,
   output logic [PW:0]       o_level
`endif
);

   logic [0:0]          state_q, state_d;
   logic [PW-1:0]       issue_ptr_q, issue_ptr_d;
   logic [PW-1:0]       read_ptr_q, read_ptr_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic                req_q, req_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                exp_q, exp_d;
   logic                empty_q, empty_d;

   logic                issue;
   logic                fifo_clear;
   logic                fifo_push;
   logic                fifo_pop;
   logic [BYTE_W-1:0]   fifo_head;
   logic                fifo_valid;

   // Next-state logic: issue/return/pop in RUN, drain in-flight read then resync in FLUSH
   always_comb begin
      state_d     = state_q;
      issue_ptr_d = issue_ptr_q;
      read_ptr_d  = read_ptr_q;
      credits_d   = credits_q;
      req_d       = 1'b0;
      addr_d      = addr_q;
      exp_d       = req_q;
      issue       = 1'b0;
      fifo_clear  = 1'b0;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (i_flush) begin
               state_d    = ST_FLUSH;
               fifo_clear = 1'b1;
            end else begin
               issue     = (issue_ptr_q != i_write_ptr) &&
                           (credits_q < CREDIT_W'(FIFO_DEPTH));
               fifo_push = i_mem_read_data_valid && exp_q;
               fifo_pop  = fifo_valid && i_data_ready;
               if (issue) begin
                  req_d       = 1'b1;
                  addr_d      = issue_ptr_q[AW-1:0];
                  issue_ptr_d = issue_ptr_q + PW'(1);
               end
               if (fifo_pop) begin
                  read_ptr_d = read_ptr_q + PW'(1);
               end
               credits_d = credits_q + CREDIT_W'(issue) - CREDIT_W'(fifo_pop);
            end
         end
         ST_FLUSH: begin
            fifo_clear = 1'b1;
            if (!req_q && !exp_q) begin
               state_d     = ST_RUN;
               issue_ptr_d = i_write_ptr;
               read_ptr_d  = i_write_ptr;
               credits_d   = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      empty_d = (issue_ptr_d == i_write_ptr) && (credits_d == '0);
   end

   // Pointer, credit, request and state registers
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_RUN;
         issue_ptr_q <= '0;
         read_ptr_q  <= '0;
         credits_q   <= '0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         exp_q       <= 1'b0;
         empty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_ptr_q <= issue_ptr_d;
         read_ptr_q  <= read_ptr_d;
         credits_q   <= credits_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         exp_q       <= exp_d;
         empty_q     <= empty_d;
      end
   end

   queue_reader_fifo u_fifo (
      .clk          (i_master_clk),
      .rst_n        (i_reset_n),
      .i_clear      (fifo_clear),
      .i_push       (fifo_push),
      .i_push_data  (i_mem_read_data),
      .i_pop        (fifo_pop),
      .o_head       (fifo_head),
      .o_head_valid (fifo_valid)
   );

   assign o_read_ptr         = read_ptr_q;
   assign o_mem_read_address = addr_q;
   assign o_mem_read_request = req_q;
   assign o_data             = fifo_head;
   assign o_data_valid       = fifo_valid;
   assign o_empty            = empty_q;

`ifdef QUEUE_READER_LEVEL_EN
   logic [PW:0]   level_q, level_d;
   logic [PW-1:0] level_diff;

   // Unread-byte count against the post-edge read pointer; forced to zero while flushing
   always_comb begin
      level_diff = i_write_ptr - read_ptr_d;
      level_d    = (state_d == ST_RUN) ? {1'b0, level_diff} : '0;
   end

   // Level register
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign o_level = level_q;
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: directed stimulus feeds an expected-byte
// scoreboard; a monitor pops and compares on every stream handshake.
module tb_queue_reader;

   localparam int unsigned PW = 11;
   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] wp = '0;
   logic [PW-1:0] o_read_ptr;
   logic [AW-1:0] o_mem_read_address;
   logic          o_mem_read_request;
   logic [7:0]    mem_data = 8'h00;
   logic          mem_valid = 1'b0;
   logic [7:0]    o_data;
   logic          o_data_valid;
   logic          ready = 1'b0;
   logic          flush = 1'b0;
   logic          o_empty;
`ifdef QUEUE_READER_LEVEL_EN
   logic [PW:0]   o_level;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0]    sb[$];
   logic [AW-1:0] req_log[$];
   int            hs_cyc[$];

   queue_reader #(.SIZE_KB(1)) dut (
      .i_master_clk          (clk),
      .i_reset_n             (rst_n),
      .i_write_ptr           (wp),
      .o_read_ptr            (o_read_ptr),
      .o_mem_read_address    (o_mem_read_address),
      .o_mem_read_request    (o_mem_read_request),
      .i_mem_read_data       (mem_data),
      .i_mem_read_data_valid (mem_valid),
      .o_data                (o_data),
      .o_data_valid          (o_data_valid),
      .i_data_ready          (ready),
      .i_flush               (flush),
      .o_empty               (o_empty)
`ifdef QUEUE_READER_LEVEL_EN
      ,
      .o_level               (o_level)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: byte at address a is a[7:0]^A5, returned one cycle after request
   always @(posedge clk) begin
      mem_valid <= o_mem_read_request;
      mem_data  <= o_mem_read_request ? (o_mem_read_address[7:0] ^ 8'hA5) : 8'h00;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [PW-1:0] p);
      return p[7:0] ^ 8'hA5;
   endfunction

   // Stream monitor: a handshake happens at the next rising edge
   always @(negedge clk) begin
      if (rst_n && o_data_valid && ready && !flush) begin
         hs_cyc.push_back(cyc);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL stream_unexpected actual=%0h expected=none", o_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (o_data !== e) begin
               failures++;
               $display("FAIL stream_data actual=%0h expected=%0h", o_data, e);
            end
         end
      end
      if (rst_n && o_mem_read_request) req_log.push_back(o_mem_read_address);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_wp(input logic [PW-1:0] nw);
      logic [PW-1:0] p;
      p = wp;
      while (p != nw) begin
         sb.push_back(exp_byte(p));
         p = p + PW'(1);
      end
      wp = nw;
   endtask

   task automatic wait_empty(input string name, input int bound);
      int n;
      n = 0;
      step(2);
      while (!o_empty && n < bound) begin
         step(1);
         n++;
      end
      chk(name, 32'(o_empty), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #12;
      chk("rst_read_ptr", 32'(o_read_ptr), 0);
      chk("rst_request", 32'(o_mem_read_request), 0);
      chk("rst_valid", 32'(o_data_valid), 0);
      chk("rst_empty", 32'(o_empty), 0);
      rst_n = 1'b1;
      ready = 1'b1;
      step(2);
      chk("idle_empty", 32'(o_empty), 1);

      // Test 1: single byte, latency
      set_wp(11'd1);
      step(1);
      chk("t1_req", 32'(o_mem_read_request), 1);
      chk("t1_addr", 32'(o_mem_read_address), 0);
      chk("t1_not_empty", 32'(o_empty), 0);
      step(1);
      chk("t1_req_drop", 32'(o_mem_read_request), 0);
      chk("t1_valid_early", 32'(o_data_valid), 0);
      step(1);
      chk("t1_valid", 32'(o_data_valid), 1);
      chk("t1_data", 32'(o_data), 32'h A5);
      step(1);
      chk("t1_valid_after", 32'(o_data_valid), 0);
      chk("t1_read_ptr", 32'(o_read_ptr), 1);
      chk("t1_empty", 32'(o_empty), 1);

      // Test 2: 16 bytes back to back
      hs_cyc.delete();
      set_wp(11'd17);
      wait_empty("t2_drain", 60);
      chk("t2_count", hs_cyc.size(), 16);
      if (hs_cyc.size() == 16) chk("t2_consecutive", hs_cyc[15] - hs_cyc[0], 15);
      chk("t2_read_ptr", 32'(o_read_ptr), 17);
      chk("t2_sb_left", sb.size(), 0);
`ifdef QUEUE_READER_LEVEL_EN
      chk("t2_level", 32'(o_level), 0);
`endif

      // Test 3: stalled consumer, credit limit
      ready = 1'b0;
      req_log.delete();
      hs_cyc.delete();
      set_wp(11'd33);
      step(10);
      chk("t3_req_count", req_log.size(), 4);
      chk("t3_valid", 32'(o_data_valid), 1);
      chk("t3_read_ptr_hold", 32'(o_read_ptr), 17);
`ifdef QUEUE_READER_LEVEL_EN
      chk("t3_level", 32'(o_level), 16);
`endif
      ready = 1'b1;
      wait_empty("t3_drain", 60);
      chk("t3_count", hs_cyc.size(), 16);
      chk("t3_read_ptr", 32'(o_read_ptr), 33);
      chk("t3_sb_left", sb.size(), 0);

      // Test 5: flush with a read in flight
      ready = 1'b0;
      set_wp(11'd41);
      step(1);
      chk("t5_inflight", 32'(o_mem_read_request), 1);
      flush = 1'b1;
      sb.delete();
      step(1);
      flush = 1'b0;
      chk("t5_valid0", 32'(o_data_valid), 0);
      step(1);
      chk("t5_valid1", 32'(o_data_valid), 0);
      step(1);
      chk("t5_valid2", 32'(o_data_valid), 0);
      chk("t5_read_ptr", 32'(o_read_ptr), 41);
      chk("t5_empty", 32'(o_empty), 1);
      ready = 1'b1;
      set_wp(11'd43);
      wait_empty("t5_resume", 40);
      chk("t5_resume_ptr", 32'(o_read_ptr), 43);
      chk("t5_sb_left", sb.size(), 0);

      // Test 4: wrap around the end of the queue
      wp = 11'd1022;
      flush = 1'b1;
      sb.delete();
      step(1);
      flush = 1'b0;
      begin
         int n;
         n = 0;
         while (!(o_empty && o_read_ptr == 11'd1022) && n < 4) begin
            step(1);
            n++;
         end
      end
      chk("t4_resync", 32'(o_read_ptr), 1022);
      req_log.delete();
      set_wp(11'd1026);
      wait_empty("t4_drain", 40);
      chk("t4_req_count", req_log.size(), 4);
      if (req_log.size() == 4) begin
         chk("t4_addr0", 32'(req_log[0]), 1022);
         chk("t4_addr1", 32'(req_log[1]), 1023);
         chk("t4_addr2", 32'(req_log[2]), 0);
         chk("t4_addr3", 32'(req_log[3]), 1);
      end
      chk("t4_read_ptr", 32'(o_read_ptr), 32'h402);
      chk("t4_sb_left", sb.size(), 0);

      // Test 6: asynchronous reset mid-stream, late memory valid discarded
      ready = 1'b0;
      set_wp(11'd1032);
      step(2);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t6_read_ptr", 32'(o_read_ptr), 0);
      chk("t6_request", 32'(o_mem_read_request), 0);
      chk("t6_addr", 32'(o_mem_read_address), 0);
      chk("t6_valid", 32'(o_data_valid), 0);
      chk("t6_data", 32'(o_data), 0);
      chk("t6_empty", 32'(o_empty), 0);
      wp = '0;
      #1;
      rst_n = 1'b1;
      step(3);
      chk("t6_late_valid", 32'(o_data_valid), 0);
      chk("t6_idle_empty", 32'(o_empty), 1);
      ready = 1'b1;
      set_wp(11'd2);
      wait_empty("t6_resume", 40);
      chk("t6_resume_ptr", 32'(o_read_ptr), 2);
      chk("t6_sb_left", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
